// File: rtl/imm_decode_stage.sv
// Decode-stage front end: classifies the fetched opcode, builds the sign-extended immediate and
// buffers results in a two-entry skid buffer. IMM_DECODE_ZICSR_EN enables Zicsr immediate (CSRR*I) decode.
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_sel,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    SEL_NONE = 4'd0,
    SEL_I    = 4'd1,
    SEL_S    = 4'd2,
    SEL_B    = 4'd3,
    SEL_U    = 4'd4,
    SEL_J    = 4'd5,
    SEL_Z    = 4'd6
  } sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    sel_e            sel;
    logic            illegal;
  } entry_t;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  sel_e   dec_sel;
  logic   dec_illegal;
  logic   in_xfer, out_xfer;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_sel     = SEL_NONE;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      7'b0110111, 7'b0010111:                         dec_sel = SEL_U;
      7'b1101111:                                     dec_sel = SEL_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: dec_sel = SEL_I;
      7'b1100011:                                     dec_sel = SEL_B;
      7'b0100011:                                     dec_sel = SEL_S;
      7'b0110011:                                     dec_sel = SEL_NONE;
      7'b1110011: begin
`ifdef IMM_DECODE_ZICSR_EN
        if (in_inst[14]) dec_sel = SEL_Z;
`else
        if (in_inst[13:12] != 2'b00) dec_illegal = 1'b1;
`endif
      end
      default:                                        dec_illegal = 1'b1;
    endcase

    dec         = '0;
    dec.inst    = in_inst;
    dec.pc      = in_pc;
    dec.sel     = dec_sel;
    dec.illegal = dec_illegal;
    case (dec_sel)
      SEL_I:   dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
      SEL_S:   dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      SEL_B:   dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                          in_inst[11:8], 1'b0};
      SEL_U:   dec.imm = {in_inst[31:12], 12'b0};
      SEL_J:   dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                          in_inst[30:21], 1'b0};
      SEL_Z:   dec.imm = {27'b0, in_inst[19:15]};
      default: dec.imm = '0;
    endcase
  end

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_d  = dec;
            state_d = ST_TWO;
          end else if (out_xfer && !in_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer && out_xfer) begin
            main_d  = dec;
          end
        end
        ST_TWO: begin
          // Upstream is already stalled here, so only the drain side can move.
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  // NOTE: payload registers are reset too, because their reset values are visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_inst    = main_q.inst;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_sel     = main_q.sel;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage; follows IMM_DECODE_ZICSR_EN like the design.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [3:0]  out_sel;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  imm_decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_sel     (out_sel),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge, inputs are changed at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_inst"}, out_inst, 32'd0);
    check({tag, "_pc"}, out_pc, 32'd0);
    check({tag, "_imm"}, out_imm, 32'd0);
    check({tag, "_sel"}, {28'b0, out_sel}, 32'd0);
    check({tag, "_ill"}, {31'b0, out_illegal}, 32'd0);
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [3:0] sel, input logic ill);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_imm"}, out_imm, imm);
    check({tag, "_sel"}, {28'b0, out_sel}, {28'b0, sel});
    check({tag, "_ill"}, {31'b0, out_illegal}, {31'b0, ill});
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ADDI x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h0000_0100);
    step();
    check_out("addi", 32'h100, 32'hFFFF_FFFF, 4'd1, 1'b0);
    check("addi_inst", out_inst, 32'hFFF00093);

    // BEQ then LUI back-to-back
    drive(1'b1, 32'hFE000EE3, 32'h0000_0104);
    step();
    check_out("beq", 32'h104, 32'hFFFF_FFFC, 4'd3, 1'b0);
    drive(1'b1, 32'h12345137, 32'h0000_0108);
    step();
    check_out("lui", 32'h108, 32'h1234_5000, 4'd4, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // Stall: three offered with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 32'h00500113, 32'h0000_0200);   // addi x2,x0,5
    step();
    check_out("stall_a", 32'h200, 32'd5, 4'd1, 1'b0);
    check("stall_a_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h00112223, 32'h0000_0204);   // sw x1,4(x2)
    step();
    check("stall_b_ready", {31'b0, in_ready}, 32'd0);
    check_out("stall_frz1", 32'h200, 32'd5, 4'd1, 1'b0);
    drive(1'b1, 32'h0080006F, 32'h0000_0208);   // jal x0,8
    step();
    check("stall_c_ready", {31'b0, in_ready}, 32'd0);
    check_out("stall_frz2", 32'h200, 32'd5, 4'd1, 1'b0);
    out_ready = 1'b1;
    step();
    check_out("drain_b", 32'h204, 32'd4, 4'd2, 1'b0);
    check("drain_b_ready", {31'b0, in_ready}, 32'd1);
    step();
    check_out("drain_c", 32'h208, 32'd8, 4'd5, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("drain_c_empty", {31'b0, out_valid}, 32'd0);

    // SYSTEM encodings and an illegal word
    drive(1'b1, 32'h3002D073, 32'h0000_0300);   // csrrwi x0,mstatus,5
    step();
`ifdef IMM_DECODE_ZICSR_EN
    check_out("csrrwi", 32'h300, 32'd5, 4'd6, 1'b0);
`else
    check_out("csrrwi", 32'h300, 32'd0, 4'd0, 1'b1);
`endif
    drive(1'b1, 32'h00000073, 32'h0000_0304);   // ecall
    step();
    check_out("ecall", 32'h304, 32'd0, 4'd0, 1'b0);
    drive(1'b1, 32'h00000000, 32'h0000_0308);
    step();
    check_out("illegal0", 32'h308, 32'd0, 4'd0, 1'b1);
    drive(1'b1, 32'h00000090, 32'h0000_030C);   // low bits != 11
    step();
    check_out("illegal_lo", 32'h30C, 32'd0, 4'd0, 1'b1);
    drive(1'b0, 32'h0, 32'h0);
    step();

    // Flush from TWO, then flush with a capturable input in EMPTY
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h0000_0400);
    step();
    drive(1'b1, 32'h00200093, 32'h0000_0404);
    step();
    check("fl_two_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00300093, 32'h0000_0408);
    step();
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    check("fl_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 32'h00400093, 32'h0000_040C);
    step();
    check("fl_empty_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h0000_0410);
    step();
    check_out("fl_recover", 32'h410, 32'd5, 4'd1, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("fl_recover_empty", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h0000_0500);
    step();
    drive(1'b1, 32'h12345137, 32'h0000_0504);
    step();
    check("prerst_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst_valid", {31'b0, out_valid}, 32'd0);
    check("postrst_ready", {31'b0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Decode-stage front end that accepts fetched instructions over a valid/ready handshake, classifies each opcode into an immediate format, generates the sign-extended 32-bit immediate, and presents it with the PC and instruction to execute. It sits between fetch and the register-read/execute stage. A two-entry skid buffer fully registers the upstream ready path, so back-pressure never combinationally reaches fetch.

## Interface
- XLEN, 32: datapath width; only 32 is supported.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  32  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  downstream accepts
- out_inst  out  32  instruction word
- out_pc  out  32  instruction address
- out_imm  out  32  sign-extended immediate
- out_sel  out  4  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
- out_illegal  out  1  unrecognised encoding; out_imm = 0, out_sel = 0

## Operation
- Classification uses inst[6:0]:
  - 0110111/0010111 → U
  - 1101111 → J
  - 1100111, 0000011, 0010011, 0001111 → I
  - 1100011 → B
  - 0100011 → S
  - 0110011 → none
  - 1110011 → Z if inst[14] = 1, otherwise none (when inst[13:12] ≠ 00) or none (ECALL/EBREAK group)
  - Any other opcode, or inst[1:0] ≠ 11 → illegal
- Immediates (RISC-V base spec):
  - I = sext(inst[31:20])
  - S = sext({inst[31:25], inst[11:7]})
  - B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - U = {inst[31:12], 12'b0}
  - J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
  - Z = {27'b0, inst[19:15]}
  - none = 0
- Decode is combinational on the input side. Results are written into the main output register, which is entry 0.
- Skid buffer states: EMPTY, ONE (main valid), TWO (main + skid valid).
  - in_ready = (state ≠ TWO), registered.
  - out_valid = (state ≠ EMPTY).
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- Transitions:
  - EMPTY: in → ONE.
  - ONE: in & !out → TWO, with the new entry placed in skid. Out & !in → EMPTY. In & out → ONE, with main replaced.
  - TWO: out → ONE, with skid moved to main. Input is never accepted in TWO.
- Entries retire in order. No entry is duplicated or dropped.
- flush takes priority over everything in that cycle:
  - Next state is EMPTY; in_ready is 1 in the next cycle.
  - A concurrent in_valid is not captured.
  - A concurrent out transfer is still considered consumed by downstream.

## Timing
- Latency: 1 cycle. An input accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 per cycle while out_ready is held high.
- Reset (asynchronous assert, synchronous-safe release) sets:
  - state EMPTY, out_valid 0, in_ready 1
  - out_inst, out_pc, out_imm 0; out_sel 0; out_illegal 0
- Reset mid-stream drops all buffered entries.
- Output payload is stable while out_valid & !out_ready. Payload is don't-care when out_valid = 0 but held at its last value.
- in_ready depends only on state, never on out_ready in the same cycle.

## Configuration
- IMM_DECODE_ZICSR_EN
  - Defined: SYSTEM opcodes decode as above; Z-format is produced for CSRR*I.
  - Undefined: every 1110011 encoding with inst[13:12] ≠ 00 is flagged illegal with out_imm 0. ECALL/EBREAK stay legal with sel none. out_sel value 6 is never produced.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), out_ready = 1 → one cycle later: out_imm 0xFFFFFFFF, out_sel 1, out_illegal 0.
- BEQ x0,x0,-4 (0xFE000EE3), then LUI (0x12345137) back-to-back → out_imm 0xFFFFFFFC with sel 3, then 0x12345000 with sel 4, on consecutive cycles.
- Stall: out_ready = 0 while 3 instructions are offered →
  - Two are accepted; in_ready falls after the second.
  - Outputs stay frozen on the first.
  - Releasing out_ready drains both in order; the third is accepted after the drain.
- CSRRWI x0,mstatus,5 (0x3002D073):
  - With IMM_DECODE_ZICSR_EN: imm 5, sel 6.
  - Without it: out_illegal 1, imm 0.
- Illegal word 0x00000000 → out_illegal 1, out_sel 0, out_imm 0.
- State TWO, then flush with in_valid = 1 → next cycle out_valid 0 and in_ready 1. The flush-cycle input never appears. rst_n pulsed low mid-stream → all outputs go to reset values asynchronously.
